// File: rtl/viterbi_chan_inj.sv
// Channel model between convolutional encoder and Viterbi decoder: fixed-latency symbol
// pipeline with clean/random/periodic/burst bit-error injection and windowed error statistics.
module viterbi_chan_inj #(
  parameter int unsigned SYM_W   = 2,
  parameter int unsigned DELAY   = 1,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned BURST_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode_i,
  input  logic               mask_sel_i,
  input  logic [15:0]        thresh_i,
  input  logic [15:0]        period_i,
  input  logic [BURST_W-1:0] burst_len_i,
  input  logic [15:0]        seed_i,
  input  logic               seed_load_i,
  input  logic               clr_stats_i,
  input  logic [CNT_W-1:0]   window_i,
  input  logic               sym_valid_i,
  input  logic [SYM_W-1:0]   sym_i,
  output logic               sym_valid_o,
  output logic [SYM_W-1:0]   sym_o,
  output logic [SYM_W-1:0]   err_mask_o,
  output logic [CNT_W-1:0]   sym_ct_o,
  output logic [CNT_W-1:0]   bad_sym_ct_o,
  output logic [CNT_W-1:0]   bad_bit_ct_o,
  output logic               window_done_o
);

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] LfsrTaps = 16'hB400;

  typedef enum logic {StIdle, StBurst} burst_st_e;

  logic [15:0]        lfsr_q, lfsr_d;
  logic [15:0]        per_cnt_q, per_cnt_d, per_next;
  burst_st_e          burst_q;
  logic [BURST_W-1:0] rem_q;
  logic               trig;
  logic [SYM_W-1:0]   base_mask, mask;

  logic [DELAY-1:0]   vld_q;
  logic [SYM_W-1:0]   sym_pq  [DELAY];
  logic [SYM_W-1:0]   mask_pq [DELAY];

  logic [CNT_W-1:0]   sym_ct_q, bad_sym_ct_q, bad_bit_ct_q;
  logic               win_done_q, win_hit, cnt_en;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] popcnt(input logic [SYM_W-1:0] m);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(SYM_W); i++) c = c + CNT_W'(m[i]);
    return c;
  endfunction

  always_comb begin
    lfsr_d = lfsr_q;
    if (seed_load_i) begin
      lfsr_d = (seed_i == 16'h0000) ? 16'h0001 : seed_i;
    end else if (sym_valid_i) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrTaps : 16'h0000);
    end
  end

  assign trig     = lfsr_q < thresh_i;
  assign per_next = per_cnt_q + 16'd1;

  always_comb begin
    base_mask = '1;
    if (mask_sel_i) begin
      base_mask = (lfsr_q[SYM_W-1:0] == '0) ? SYM_W'(1) : lfsr_q[SYM_W-1:0];
    end
  end

  // Stage-0 decision uses the pre-advance LFSR value.
  always_comb begin
    mask      = '0;
    per_cnt_d = per_cnt_q;
    if (sym_valid_i) begin
      unique case (mode_i)
        2'd0: mask = '0;
        2'd1: if (trig) mask = base_mask;
        2'd2: begin
          if (period_i == 16'd0) begin
            per_cnt_d = 16'd0;
          end else if (per_next == period_i) begin
            mask      = base_mask;
            per_cnt_d = 16'd0;
          end else begin
            per_cnt_d = per_next;
          end
        end
        2'd3: if (burst_q == StBurst || (trig && burst_len_i != '0)) mask = base_mask;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q    <= 16'h0001;
      per_cnt_q <= 16'd0;
    end else begin
      lfsr_q    <= lfsr_d;
      per_cnt_q <= per_cnt_d;
    end
  end

  // Burst length counts the triggering symbol, so a length of 1 never enters StBurst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      burst_q <= StIdle;
      rem_q   <= '0;
    end else if (mode_i != 2'd3) begin
      burst_q <= StIdle;
    end else if (sym_valid_i) begin
      unique case (burst_q)
        StIdle: begin
          if (trig && burst_len_i != '0) begin
            rem_q <= burst_len_i - BURST_W'(1);
            if (burst_len_i != BURST_W'(1)) burst_q <= StBurst;
          end
        end
        StBurst: begin
          rem_q <= rem_q - BURST_W'(1);
          if (rem_q <= BURST_W'(1)) burst_q <= StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < int'(DELAY); i++) begin
        sym_pq[i]  <= '0;
        mask_pq[i] <= '0;
      end
    end else begin
      vld_q[0]   <= sym_valid_i;
      sym_pq[0]  <= sym_valid_i ? (sym_i ^ mask) : '0;
      mask_pq[0] <= mask;
      for (int i = 1; i < int'(DELAY); i++) begin
        vld_q[i]   <= vld_q[i-1];
        sym_pq[i]  <= sym_pq[i-1];
        mask_pq[i] <= mask_pq[i-1];
      end
    end
  end

  assign sym_valid_o = vld_q[DELAY-1];
  assign sym_o       = sym_pq[DELAY-1];
  assign err_mask_o  = mask_pq[DELAY-1];

  assign win_hit = (window_i != '0) && (sym_ct_q == window_i);
  assign cnt_en  = sym_valid_o && !win_done_q && !win_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sym_ct_q     <= '0;
      bad_sym_ct_q <= '0;
      bad_bit_ct_q <= '0;
      win_done_q   <= 1'b0;
    end else if (clr_stats_i) begin
      sym_ct_q     <= '0;
      bad_sym_ct_q <= '0;
      bad_bit_ct_q <= '0;
      win_done_q   <= 1'b0;
    end else begin
      if (cnt_en) begin
        sym_ct_q     <= sat_add(sym_ct_q, CNT_W'(1));
        bad_sym_ct_q <= sat_add(bad_sym_ct_q, CNT_W'(|err_mask_o));
        bad_bit_ct_q <= sat_add(bad_bit_ct_q, popcnt(err_mask_o));
      end
      win_done_q <= win_done_q | win_hit;
    end
  end

  assign sym_ct_o      = sym_ct_q;
  assign bad_sym_ct_o  = bad_sym_ct_q;
  assign bad_bit_ct_o  = bad_bit_ct_q;
  assign window_done_o = win_done_q;

endmodule

// File: tb/tb_viterbi_chan_inj.sv
// Scoreboard bench for viterbi_chan_inj: a reference error model pushes expected symbol/mask
// pairs when stimulus is driven; a negedge monitor pops and compares them at the output.
module tb_viterbi_chan_inj;

  localparam int unsigned SymW   = 2;
  localparam int unsigned Delay  = 3;
  localparam int unsigned CntW   = 32;
  localparam int unsigned BurstW = 4;

  logic              clk, rst;
  logic [1:0]        mode_i;
  logic              mask_sel_i;
  logic [15:0]       thresh_i, period_i, seed_i;
  logic [BurstW-1:0] burst_len_i;
  logic              seed_load_i, clr_stats_i;
  logic [CntW-1:0]   window_i;
  logic              sym_valid_i;
  logic [SymW-1:0]   sym_i;
  logic              sym_valid_o;
  logic [SymW-1:0]   sym_o, err_mask_o;
  logic [CntW-1:0]   sym_ct_o, bad_sym_ct_o, bad_bit_ct_o;
  logic              window_done_o;

  viterbi_chan_inj #(
    .SYM_W   (SymW),
    .DELAY   (Delay),
    .CNT_W   (CntW),
    .BURST_W (BurstW)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .mode_i        (mode_i),
    .mask_sel_i    (mask_sel_i),
    .thresh_i      (thresh_i),
    .period_i      (period_i),
    .burst_len_i   (burst_len_i),
    .seed_i        (seed_i),
    .seed_load_i   (seed_load_i),
    .clr_stats_i   (clr_stats_i),
    .window_i      (window_i),
    .sym_valid_i   (sym_valid_i),
    .sym_i         (sym_i),
    .sym_valid_o   (sym_valid_o),
    .sym_o         (sym_o),
    .err_mask_o    (err_mask_o),
    .sym_ct_o      (sym_ct_o),
    .bad_sym_ct_o  (bad_sym_ct_o),
    .bad_bit_ct_o  (bad_bit_ct_o),
    .window_done_o (window_done_o)
  );

  typedef struct {
    logic [SymW-1:0] sym;
    logic [SymW-1:0] mask;
    int              cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp, n_err;
  int   cyc;

  // Reference model state.
  logic [15:0] m_lfsr;
  int          m_per;
  int          m_rem;
  bit          m_burst;
  int          e_sym, e_bad, e_bits;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sym_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_valid", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("sym_o", 64'(sym_o), 64'(e.sym));
        check_eq("err_mask_o", 64'(err_mask_o), 64'(e.mask));
        check_eq("latency", 64'(cyc - e.cyc), 64'(Delay));
      end
    end else begin
      check_eq("idle_zero", 64'({sym_o, err_mask_o}), 64'd0);
    end
  end

  function automatic int pop2(input logic [1:0] m);
    return int'(m[0]) + int'(m[1]);
  endfunction

  task automatic model_step(output logic [1:0] mask);
    logic [1:0] base;
    bit         trig;
    mask = 2'b00;
    base = 2'b11;
    if (mask_sel_i) base = (m_lfsr[1:0] == 2'b00) ? 2'b01 : m_lfsr[1:0];
    trig = (m_lfsr < thresh_i);
    if (mode_i != 2'd3) m_burst = 0;
    case (mode_i)
      2'd1: if (trig) mask = base;
      2'd2: begin
        if (period_i == 0) begin
          m_per = 0;
        end else begin
          m_per++;
          if (m_per == int'(period_i)) begin
            mask  = base;
            m_per = 0;
          end
        end
      end
      2'd3: begin
        if (m_burst) begin
          mask = base;
          m_rem--;
          if (m_rem == 0) m_burst = 0;
        end else if (trig && burst_len_i != 0) begin
          mask    = base;
          m_rem   = int'(burst_len_i) - 1;
          m_burst = (m_rem != 0);
        end
      end
      default: mask = 2'b00;
    endcase
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  endtask

  task automatic send(input logic [1:0] s);
    logic [1:0] m;
    exp_t       e;
    model_step(m);
    sym_i       = s;
    sym_valid_i = 1'b1;
    e.sym  = s ^ m;
    e.mask = m;
    e.cyc  = cyc;
    exp_q.push_back(e);
    e_sym++;
    if (m != 2'b00) e_bad++;
    e_bits += pop2(m);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    sym_valid_i = 1'b0;
    sym_i       = '0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    sym_valid_i = 1'b0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) check_eq("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    drain();
    clr_stats_i = 1'b1;
    @(posedge clk); #1;
    clr_stats_i = 1'b0;
    e_sym  = 0;
    e_bad  = 0;
    e_bits = 0;
  endtask

  task automatic load_seed(input logic [15:0] s);
    seed_i      = s;
    seed_load_i = 1'b1;
    @(posedge clk); #1;
    seed_load_i = 1'b0;
    m_lfsr      = (s == 16'h0000) ? 16'h0001 : s;
  endtask

  task automatic check_stats(input string tag, input int s, input int b, input int bits);
    check_eq({tag, "_sym_ct"}, 64'(sym_ct_o), 64'(s));
    check_eq({tag, "_bad_sym_ct"}, 64'(bad_sym_ct_o), 64'(b));
    check_eq({tag, "_bad_bit_ct"}, 64'(bad_bit_ct_o), 64'(bits));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    rst = 1'b0;
    mode_i = 2'd0; mask_sel_i = 1'b0; thresh_i = '0; period_i = '0; burst_len_i = '0;
    seed_i = '0; seed_load_i = 1'b0; clr_stats_i = 1'b0; window_i = '0;
    sym_valid_i = 1'b0; sym_i = '0;
    m_lfsr = 16'h0001; m_per = 0; m_rem = 0; m_burst = 0;
    e_sym = 0; e_bad = 0; e_bits = 0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 64'(sym_valid_o), 64'd0);
    check_eq("rst_done", 64'(window_done_o), 64'd0);
    check_stats("rst", 0, 0, 0);
    rst = 1'b1;
    idle(2);

    // Clean channel.
    for (int i = 0; i < 300; i++) send(2'($urandom));
    drain();
    check_stats("clean", 300, 0, 0);

    // Periodic inversion every 4th symbol.
    clear_stats();
    mode_i = 2'd2; period_i = 16'd4; mask_sel_i = 1'b0;
    for (int i = 0; i < 100; i++) send(2'($urandom));
    drain();
    check_stats("periodic", 100, 25, 50);

    // Random mode with LFSR-derived masks.
    clear_stats();
    load_seed(16'hACE1);
    mode_i = 2'd1; thresh_i = 16'hFFFF; mask_sel_i = 1'b1;
    for (int i = 0; i < 200; i++) send(2'($urandom));
    idle(1);
    for (int i = 0; i < 40; i++) send(2'($urandom));
    drain();
    check_stats("random", e_sym, e_bad, e_bits);

    // Burst cut short by a mode change, then no stale burst on return.
    clear_stats();
    mode_i = 2'd3; thresh_i = 16'hFFFF; burst_len_i = 4'd3; mask_sel_i = 1'b0;
    send(2'b01);
    send(2'b10);
    mode_i = 2'd0;
    for (int i = 0; i < 3; i++) send(2'($urandom));
    mode_i = 2'd3; thresh_i = 16'h0000;
    for (int i = 0; i < 3; i++) send(2'($urandom));
    drain();
    check_stats("burst", 8, 2, 4);

    // Measurement window.
    mode_i = 2'd0; window_i = 10;
    clear_stats();
    for (int i = 0; i < 15; i++) send(2'($urandom));
    drain();
    check_stats("window", 10, 0, 0);
    check_eq("window_done_set", 64'(window_done_o), 64'd1);
    clr_stats_i = 1'b1;
    @(posedge clk); #1;
    clr_stats_i = 1'b0;
    check_stats("window_clr", 0, 0, 0);
    check_eq("window_done_clr", 64'(window_done_o), 64'd0);
    for (int i = 0; i < 5; i++) send(2'($urandom));
    drain();
    check_stats("window_resume", 5, 0, 0);
    check_eq("window_done_resume", 64'(window_done_o), 64'd0);
    window_i = 0;

    // Asynchronous reset with symbols in flight.
    mode_i = 2'd1; thresh_i = 16'h8000; mask_sel_i = 1'b1;
    for (int i = 0; i < 5; i++) send(2'($urandom));
    sym_valid_i = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    check_eq("midrst_valid", 64'(sym_valid_o), 64'd0);
    check_stats("midrst", 0, 0, 0);
    exp_q.delete();
    m_lfsr = 16'h0001; m_per = 0; m_rem = 0; m_burst = 0;
    e_sym = 0; e_bad = 0; e_bits = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1);
    for (int i = 0; i < 30; i++) send(2'($urandom));
    drain();
    check_stats("post_rst", e_sym, e_bad, e_bits);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/viterbi_chan_inj.md
Name: viterbi_chan_inj

Overview:
- Parametrised channel model placed between the convolutional encoder and the Viterbi decoder in the tx/rx loopback.
- Delays encoded symbols by a fixed pipeline depth.
- Injects bit errors in one of four modes: clean, random, periodic or burst.
- Keeps saturating symbol, bad-symbol and bad-bit statistics over a programmable measurement window.

Parameters:
- SYM_W, 2: bits per encoded symbol (code rate 1/SYM_W).
- DELAY, 1: pipeline depth from input to output, in cycles. Legal range 1..8.
- CNT_W, 32: width of the statistics counters.
- BURST_W, 4: width of burst_len_i.

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous active-low reset.
- mode_i, in, 2: injection mode. 0 clean, 1 random, 2 periodic, 3 burst.
- mask_sel_i, in, 1: error-mask source. 0 inverts all bits; 1 uses LFSR low bits.
- thresh_i, in, 16: random/burst trigger threshold. Inject when lfsr < thresh_i.
- period_i, in, 16: periodic mode interval, in valid symbols. 0 means never inject.
- burst_len_i, in, BURST_W: symbols per burst. 0 means no injection.
- seed_i, in, 16: LFSR seed.
- seed_load_i, in, 1: load seed_i into the LFSR.
- clr_stats_i, in, 1: clear statistics and window state.
- window_i, in, CNT_W: measurement window in symbols. 0 means unlimited.
- sym_valid_i, in, 1: input symbol valid.
- sym_i, in, SYM_W: encoded symbol.
- sym_valid_o, out, 1: output symbol valid.
- sym_o, out, SYM_W: possibly corrupted symbol.
- err_mask_o, out, SYM_W: XOR mask applied to sym_o, aligned with sym_o.
- sym_ct_o, out, CNT_W: valid symbols counted.
- bad_sym_ct_o, out, CNT_W: symbols with a nonzero mask.
- bad_bit_ct_o, out, CNT_W: total bits flipped.
- window_done_o, out, 1: window reached.

Behaviour:
- Reset (rst low, asynchronous): all outputs and counters go to 0, pipeline valids clear, LFSR goes to 16'h0001, period counter to 0, burst state to IDLE.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances one step per cycle with sym_valid_i high; holds otherwise.
  - seed_load_i has priority over advance. A seed of 0 loads 16'h0001.
- Mask generation (stage 0, same cycle as sym_valid_i):
  - Injection decision per valid symbol uses the current (pre-advance) LFSR value.
  - Base mask = all ones if mask_sel_i=0. Otherwise base mask = lfsr[SYM_W-1:0]; if that is zero, use 1 in bit 0.
  - Mode 0: mask is 0.
  - Mode 1: base mask if lfsr < thresh_i, else 0.
  - Mode 2: period counter increments per valid symbol. When it equals period_i, apply the base mask and reset the counter to 0. If period_i=0, the counter holds at 0 and no injection occurs.
  - Mode 3 state machine, IDLE/BURST:
    - IDLE -> BURST when lfsr < thresh_i and burst_len_i != 0. That triggering symbol is corrupted and starts remaining = burst_len_i - 1.
    - In BURST, each valid symbol is corrupted and decrements remaining. Exit to IDLE after the symbol with remaining=0.
    - Triggers are ignored while in BURST.
    - Leaving mode 3 mid-burst forces IDLE immediately; the current symbol uses the new mode.
  - Invalid input cycles produce mask 0 and do not touch the counters or state.
- Pipeline: sym_o = sym_i XOR mask, sym_valid_o and err_mask_o all appear exactly DELAY cycles after the input. Output data while sym_valid_o is low is don't-care, but is driven 0.
- Statistics:
  - Counters update on output-side valid symbols.
  - sym_ct +1 per symbol; bad_sym_ct +1 if the mask is nonzero; bad_bit_ct + popcount(mask).
  - All counters saturate at all-ones.
  - When window_i != 0 and sym_ct_o equals window_i, window_done_o goes high (registered) and all counters freeze until clr_stats_i.
  - clr_stats_i zeroes the counters and window_done_o next cycle. It takes priority over a same-cycle increment.
  - clr_stats_i does not affect the LFSR, pipeline or burst state.
- Simultaneous seed_load_i and sym_valid_i: the decision uses the old LFSR; the new seed takes effect on the next cycle.
- Config inputs are sampled per valid symbol. No shadowing.

Test Plan:
- Mode 0, 300 consecutive valid symbols, DELAY=3: sym_o equals sym_i delayed 3 cycles; all bad counts 0; sym_ct_o=300.
- Mode 2, period_i=4, mask_sel_i=0, SYM_W=2, 100 valid symbols: symbols 4, 8, ... are inverted; bad_sym_ct_o=25, bad_bit_ct_o=50.
- Mode 1, thresh_i=16'hFFFF, mask_sel_i=1, seed 16'hACE1: every symbol except those with lfsr=16'hFFFF is corrupted; err_mask_o matches a bench LFSR model bit-for-bit; bad_bit_ct_o equals the sum of mask popcounts.
- Mode 3, thresh_i=16'hFFFF, burst_len_i=3, then switch to mode 0 after the 2nd burst symbol: exactly 2 corrupted symbols; burst state is IDLE on return to mode 3.
- window_i=10 with continuous input: window_done_o goes high after the 10th output symbol, counts hold at 10; clr_stats_i clears them to 0 and counting resumes.
- Assert rst low mid-stream with valid symbols in flight: sym_valid_o drops immediately and counters read 0; after release, LFSR restarts from 16'h0001 and the mask sequence repeats the power-on sequence.
